pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Controls the pipelined CPU's program counter register and IF/ID stage. Each cycle it picks the
//  next PC, raises PC/IF-ID write enables, and issues flushes. It covers load-use stalls,
//  ID-stage jumps, EX-stage branches, instruction-memory wait states, timeout and halt.
//  Sits between the hazard/branch logic and ProgramCounter (drives its pc_write_i/pc_in_i).
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC value presented on pc_next_o during/after reset
//  WAIT_TIMEOUT 16             max consecutive imem_ready_i=0 cycles before fault
//  CNT_W        16             width of saturating stall/flush counters
// PORTS
//  clk_i            in   1      clock, all state updates on posedge
//  rst_i            in   1      synchronous reset, active-high
//  pc_i             in   32     current PC (ProgramCounter output)
//  jump_i           in   1      jump decoded in ID
//  jump_target_i    in   32     jump destination
//  branch_taken_i   in   1      branch resolved taken in EX
//  branch_target_i  in   32     branch destination
//  id_ex_memread_i  in   1      instruction in EX is a load
//  id_ex_rt_i       in   5      load destination register
//  if_id_rs_i       in   5      ID source register rs
//  if_id_rt_i       in   5      ID source register rt
//  imem_ready_i     in   1      instruction memory returns valid data this cycle
//  halt_i           in   1      halt request (e.g. break instruction in ID)
//  pc_write_o       out  1      PC load enable
//  pc_next_o        out  32     next PC value
//  if_id_write_o    out  1      IF/ID register load enable
//  if_id_flush_o    out  1      insert bubble into IF/ID
//  id_ex_flush_o    out  1      insert bubble into ID/EX
//  fault_o          out  1      sticky imem timeout flag
//  stall_cnt_o      out  CNT_W  saturating count of stall cycles
//  flush_cnt_o      out  CNT_W  saturating count of redirect (flush) events
// BEHAVIOUR
//  States: RUN, WAIT, HALTED. Outputs are combinational from state and inputs; regs update on posedge.
//  Reset (rst_i=1 at an edge): state=RUN, pending redirect cleared, wait_cnt=0, fault_o=0, counters=0.
//   While rst_i=1: pc_write_o=0, if_id_write_o=0, both flushes=1, pc_next_o=RESET_PC.
//   Reset mid-WAIT or mid-HALTED returns to RUN; any pending redirect is discarded.
//  load_use = id_ex_memread_i & id_ex_rt_i!=0 & (id_ex_rt_i==if_id_rs_i | id_ex_rt_i==if_id_rt_i).
//  RUN priority (highest first):
//   1 branch_taken_i: pc_next=branch_target, pc_write=1, if_id_flush=1, id_ex_flush=1; flush_cnt++.
//   2 halt_i: pc_write=0, if_id_write=0, id_ex_flush=1 -> HALTED.
//   3 !imem_ready_i: pc_write=0, if_id_write=0, if_id_flush=1 -> WAIT; wait_cnt=1; stall_cnt++.
//   4 load_use: pc_write=0, if_id_write=0, id_ex_flush=1 (one bubble); stall_cnt++.
//   5 jump_i: pc_next=jump_target, pc_write=1, if_id_flush=1; flush_cnt++.
//   6 default: pc_next=pc_i+4 (mod 2^32, wraps 0xFFFF_FFFC->0), pc_write=1, if_id_write=1.
//  Branch with !imem_ready_i: the branch wins. PC loads the target and IF refetches, so WAIT is not entered.
//  WAIT: pc_write=0, if_id_write=0, if_id_flush=1; stall_cnt++ each cycle.
//   branch_taken_i in WAIT: latch target into pending redirect (valid=1); id_ex_flush=1; flush_cnt++.
//   imem_ready_i=1: pc_next = pending target if valid (clear valid) else pc_i+4; pc_write=1,
//    if_id_write = !pending_valid, flush IF/ID if pending_valid; wait_cnt=0 -> RUN.
//   wait_cnt reaches WAIT_TIMEOUT with imem still not ready: fault_o=1 -> HALTED.
//  HALTED: pc_write=0, if_id_write=0, id_ex_flush=1. Leave only via reset.
//  Counters saturate at all-ones and never wrap.
// TESTING
//  T1 reset: rst_i=1 2 cycles -> pc_next_o=RESET_PC, pc_write_o=0, counters=0, fault_o=0.
//  T2 sequential: pc_i=0x0FFFFFFC, no hazards -> pc_next_o=0x10000000, pc_write_o=1; pc_i=0xFFFFFFFC -> 0.
//  T3 load-use: memread=1, id_ex_rt=5, if_id_rs=5 -> 1 cycle pc_write=0, id_ex_flush=1, stall_cnt=1.
//  T4 same cycle: branch_taken_i=1 with jump_i=1 and load_use, target 0x40 -> pc_next_o=0x40, both flushes, flush_cnt=1.
//  T5 WAIT with branch: imem_ready=0 3 cycles, branch to 0x80 in cycle 2 -> on ready, pc_next_o=0x80, if_id flushed.
//  T6 timeout: imem_ready=0 for WAIT_TIMEOUT cycles -> fault_o=1, HALTED, pc_write_o stays 0 until rst_i.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: picks the next PC and drives the PC / IF-ID write enables
// and pipeline flushes for load-use stalls, jumps, branches, imem wait
// states, imem timeout and halt.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned WAIT_TIMEOUT = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      pc_i,
    input  logic             jump_i,
    input  logic [31:0]      jump_target_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    input  logic             id_ex_memread_i,
    input  logic [4:0]       id_ex_rt_i,
    input  logic [4:0]       if_id_rs_i,
    input  logic [4:0]       if_id_rt_i,
    input  logic             imem_ready_i,
    input  logic             halt_i,
    output logic             pc_write_o,
    output logic [31:0]      pc_next_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned WCW = $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALTED} state_e;

    state_e           state_q, state_d;
    logic             pend_v_q, pend_v_d;
    logic [31:0]      pend_t_q, pend_t_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             stall_inc, flush_inc;
    logic             load_use;
    logic [31:0]      pc_plus4;

    assign load_use = id_ex_memread_i && (id_ex_rt_i != 5'd0) &&
                      ((id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i));
    assign pc_plus4 = pc_i + 32'd4;

    // Next-state and combinational control outputs, priority-ordered per state
    always_comb begin
        state_d       = state_q;
        pend_v_d      = pend_v_q;
        pend_t_d      = pend_t_q;
        wait_cnt_d    = wait_cnt_q;
        fault_d       = fault_q;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        pc_write_o    = 1'b0;
        pc_next_o     = pc_i;
        if_id_write_o = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (branch_taken_i) begin
                    pc_next_o     = branch_target_i;
                    pc_write_o    = 1'b1;
                    if_id_flush_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                    flush_inc     = 1'b1;
                end else if (halt_i) begin
                    id_ex_flush_o = 1'b1;
                    state_d       = S_HALTED;
                end else if (!imem_ready_i) begin
                    if_id_flush_o = 1'b1;
                    stall_inc     = 1'b1;
                    wait_cnt_d    = WCW'(1);
                    state_d       = S_WAIT;
                end else if (load_use) begin
                    id_ex_flush_o = 1'b1;
                    stall_inc     = 1'b1;
                end else if (jump_i) begin
                    pc_next_o     = jump_target_i;
                    pc_write_o    = 1'b1;
                    if_id_flush_o = 1'b1;
                    flush_inc     = 1'b1;
                end else begin
                    pc_next_o     = pc_plus4;
                    pc_write_o    = 1'b1;
                    if_id_write_o = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_ready_i) begin
                    // A branch resolving on the release cycle is newer than any
                    // pending redirect, so it is taken directly.
                    pc_write_o = 1'b1;
                    pend_v_d   = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = S_RUN;
                    if (branch_taken_i) begin
                        pc_next_o     = branch_target_i;
                        if_id_flush_o = 1'b1;
                        id_ex_flush_o = 1'b1;
                        flush_inc     = 1'b1;
                    end else if (pend_v_q) begin
                        pc_next_o     = pend_t_q;
                        if_id_flush_o = 1'b1;
                    end else begin
                        pc_next_o     = pc_plus4;
                        if_id_write_o = 1'b1;
                    end
                end else begin
                    if_id_flush_o = 1'b1;
                    stall_inc     = 1'b1;
                    if (branch_taken_i) begin
                        pend_v_d      = 1'b1;
                        pend_t_d      = branch_target_i;
                        id_ex_flush_o = 1'b1;
                        flush_inc     = 1'b1;
                    end
                    if (wait_cnt_q >= WCW'(WAIT_TIMEOUT - 1)) begin
                        fault_d = 1'b1;
                        state_d = S_HALTED;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WCW'(1);
                    end
                end
            end
            S_HALTED: begin
                id_ex_flush_o = 1'b1;
            end
            default: state_d = S_RUN;
        endcase
        if (rst_i) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            pc_next_o     = RESET_PC;
        end
    end

    // State, redirect, timeout and saturating counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_RUN;
            pend_v_q    <= 1'b0;
            pend_t_q    <= '0;
            wait_cnt_q  <= '0;
            fault_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_v_q   <= pend_v_d;
            pend_t_q   <= pend_t_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
            if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign fault_o     = fault_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed + randomized bench for pc_sequencer against a behavioural model.
module tb_pc_sequencer;

    localparam logic [31:0] RPC = 32'h0000_1000;
    localparam int          TO  = 16;
    localparam int          CW  = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   pc;
    logic          jump, br, memread, imem_ready, halt;
    logic [31:0]   jump_t, br_t;
    logic [4:0]    ex_rt, id_rs, id_rt;
    logic          pc_write, if_id_write, if_id_flush, id_ex_flush, fault;
    logic [31:0]   pc_next;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pc_sequencer #(.RESET_PC(RPC), .WAIT_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .pc_i(pc), .jump_i(jump), .jump_target_i(jump_t),
        .branch_taken_i(br), .branch_target_i(br_t), .id_ex_memread_i(memread),
        .id_ex_rt_i(ex_rt), .if_id_rs_i(id_rs), .if_id_rt_i(id_rt),
        .imem_ready_i(imem_ready), .halt_i(halt), .pc_write_o(pc_write),
        .pc_next_o(pc_next), .if_id_write_o(if_id_write), .if_id_flush_o(if_id_flush),
        .id_ex_flush_o(id_ex_flush), .fault_o(fault), .stall_cnt_o(stall_cnt),
        .flush_cnt_o(flush_cnt)
    );

    always #5 clk = ~clk;

    // Model: mode 0 = running, 1 = waiting on imem, 2 = halted
    int          m_mode, m_miss, m_stalls, m_flushes;
    bit          m_fault, m_redir;
    logic [31:0] m_redir_pc;
    int          n_mode, n_miss, n_stalls, n_flushes;
    bit          n_fault, n_redir;
    logic [31:0] n_redir_pc;
    bit          e_pcw, e_ifw, e_iff, e_idf;
    logic [31:0] e_pcn;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        bit hazard;
        hazard = memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
        n_mode = m_mode; n_miss = m_miss; n_fault = m_fault;
        n_redir = m_redir; n_redir_pc = m_redir_pc;
        n_stalls = m_stalls; n_flushes = m_flushes;
        e_pcw = 0; e_ifw = 0; e_iff = 0; e_idf = 0; e_pcn = pc;
        if (rst) begin
            e_iff = 1; e_idf = 1; e_pcn = RPC;
            n_mode = 0; n_miss = 0; n_fault = 0; n_redir = 0;
            n_stalls = 0; n_flushes = 0;
        end else if (m_mode == 2) begin
            e_idf = 1;
        end else if (m_mode == 0) begin
            if (br) begin
                e_pcn = br_t; e_pcw = 1; e_iff = 1; e_idf = 1;
                n_flushes = sat(m_flushes + 1);
            end else if (halt) begin
                e_idf = 1; n_mode = 2;
            end else if (!imem_ready) begin
                e_iff = 1; n_mode = 1; n_miss = 1;
                n_stalls = sat(m_stalls + 1);
            end else if (hazard) begin
                e_idf = 1; n_stalls = sat(m_stalls + 1);
            end else if (jump) begin
                e_pcn = jump_t; e_pcw = 1; e_iff = 1;
                n_flushes = sat(m_flushes + 1);
            end else begin
                e_pcn = pc + 32'd4; e_pcw = 1; e_ifw = 1;
            end
        end else if (imem_ready) begin
            e_pcw = 1; n_mode = 0; n_miss = 0; n_redir = 0;
            if (br) begin
                e_pcn = br_t; e_iff = 1; e_idf = 1;
                n_flushes = sat(m_flushes + 1);
            end else if (m_redir) begin
                e_pcn = m_redir_pc; e_iff = 1;
            end else begin
                e_pcn = pc + 32'd4; e_ifw = 1;
            end
        end else begin
            e_iff = 1; n_stalls = sat(m_stalls + 1);
            if (br) begin
                n_redir = 1; n_redir_pc = br_t; e_idf = 1;
                n_flushes = sat(m_flushes + 1);
            end
            n_miss = m_miss + 1;
            if (n_miss >= TO) begin n_fault = 1; n_mode = 2; end
        end
    endtask

    task automatic eval_check();
        #1;
        model_eval();
        chk("pc_write", 32'(pc_write), 32'(e_pcw));
        chk("pc_next", pc_next, e_pcn);
        chk("if_id_write", 32'(if_id_write), 32'(e_ifw));
        chk("if_id_flush", 32'(if_id_flush), 32'(e_iff));
        chk("id_ex_flush", 32'(id_ex_flush), 32'(e_idf));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flushes));
    endtask

    // Commit the model at the edge; PC follows the expected load enable
    task automatic tick();
        @(posedge clk);
        m_mode = n_mode; m_miss = n_miss; m_fault = n_fault;
        m_redir = n_redir; m_redir_pc = n_redir_pc;
        m_stalls = n_stalls; m_flushes = n_flushes;
        @(negedge clk);
        if (e_pcw) pc = e_pcn;
    endtask

    task automatic idle();
        rst = 0; jump = 0; br = 0; memread = 0; imem_ready = 1; halt = 0;
        jump_t = 32'h100; br_t = 32'h200; ex_rt = 0; id_rs = 0; id_rt = 0;
    endtask

    task automatic step();
        eval_check();
        tick();
    endtask

    initial begin
        logic [31:0] pc_hold;
        m_mode = 0; m_miss = 0; m_stalls = 0; m_flushes = 0;
        m_fault = 0; m_redir = 0; m_redir_pc = '0;
        idle(); pc = 32'h0;
        @(negedge clk);

        // T1 reset for two cycles
        rst = 1;
        step();
        eval_check();
        chk("T1 pc_next", pc_next, RPC);
        chk("T1 pc_write", 32'(pc_write), 32'd0);
        tick();
        rst = 0;
        eval_check();
        chk("T1 stall_cnt", 32'(stall_cnt), 32'd0);
        chk("T1 flush_cnt", 32'(flush_cnt), 32'd0);
        chk("T1 fault", 32'(fault), 32'd0);
        tick();

        // T2 sequential including 32-bit wrap
        idle(); pc = 32'h0FFF_FFFC;
        eval_check();
        chk("T2 pc_next", pc_next, 32'h1000_0000);
        chk("T2 pc_write", 32'(pc_write), 32'd1);
        tick();
        pc = 32'hFFFF_FFFC;
        eval_check();
        chk("T2 wrap", pc_next, 32'h0);
        tick();

        // T3 load-use bubble
        memread = 1; ex_rt = 5; id_rs = 5;
        eval_check();
        chk("T3 pc_write", 32'(pc_write), 32'd0);
        chk("T3 id_ex_flush", 32'(id_ex_flush), 32'd1);
        tick();
        idle();
        eval_check();
        chk("T3 stall_cnt", 32'(stall_cnt), 32'd1);
        tick();

        // T4 branch beats jump and load-use
        br = 1; br_t = 32'h40; jump = 1; memread = 1; ex_rt = 7; id_rt = 7;
        eval_check();
        chk("T4 pc_next", pc_next, 32'h40);
        chk("T4 if_id_flush", 32'(if_id_flush), 32'd1);
        chk("T4 id_ex_flush", 32'(id_ex_flush), 32'd1);
        tick();
        idle();
        eval_check();
        chk("T4 flush_cnt", 32'(flush_cnt), 32'd1);
        tick();

        // T5 wait with branch arriving in cycle 2
        idle(); imem_ready = 0;
        step();
        br = 1; br_t = 32'h80;
        step();
        br = 0;
        step();
        imem_ready = 1;
        eval_check();
        chk("T5 pc_next", pc_next, 32'h80);
        chk("T5 if_id_flush", 32'(if_id_flush), 32'd1);
        chk("T5 if_id_write", 32'(if_id_write), 32'd0);
        tick();

        // Reset mid-WAIT discards the pending redirect
        imem_ready = 0; step();
        br = 1; br_t = 32'hDEAD_0000; step();
        br = 0; rst = 1; step();
        idle(); pc_hold = pc;
        eval_check();
        chk("rstwait pc_next", pc_next, pc_hold + 32'd4);
        tick();

        // T6 timeout after TO consecutive misses, then stuck until reset
        idle(); imem_ready = 0;
        for (int i = 0; i < TO - 1; i++) step();
        chk("T6 no fault yet", 32'(fault), 32'd0);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            eval_check();
            chk("T6 fault", 32'(fault), 32'd1);
            chk("T6 pc_write", 32'(pc_write), 32'd0);
            tick();
        end
        rst = 1; step();
        idle();
        eval_check();
        chk("T6 fault cleared", 32'(fault), 32'd0);
        tick();

        // Stall counter saturation
        memread = 1; ex_rt = 3; id_rs = 3;
        for (int i = 0; i < CMAX + 5; i++) step();
        idle();
        eval_check();
        chk("sat stall_cnt", 32'(stall_cnt), 32'(CMAX));
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(63) == 0);
            halt       = ($urandom_range(47) == 0);
            imem_ready = ($urandom_range(3) != 0) || (i % 200 > 170);
            if (i % 200 > 170) imem_ready = 0;
            br         = ($urandom_range(7) == 0);
            jump       = ($urandom_range(7) == 0);
            br_t       = $urandom & 32'hFFFF_FFFC;
            jump_t     = $urandom & 32'hFFFF_FFFC;
            memread    = ($urandom_range(3) == 0);
            ex_rt      = 5'($urandom_range(3));
            id_rs      = 5'($urandom_range(3));
            id_rt      = 5'($urandom_range(3));
            if ($urandom_range(31) == 0) pc = 32'hFFFF_FFFC;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
